// File: rtl/riscv_pkg.sv
// Shared RISC-V pipeline definitions: opcode constants, hazard FSM states,
// and source-register usage decode.
package riscv_pkg;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_ADDI   = 7'b0010011;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } hz_state_t;

  // True when the instruction format actually reads rs1.
  function automatic logic uses_rs1(input logic [6:0] op);
    return (op == OP_RTYPE) || (op == OP_LOAD) || (op == OP_STORE) ||
           (op == OP_BRANCH) || (op == OP_ADDI);
  endfunction

  // True when the instruction format actually reads rs2.
  function automatic logic uses_rs2(input logic [6:0] op);
    return (op == OP_RTYPE) || (op == OP_STORE) || (op == OP_BRANCH);
  endfunction

endpackage

// File: rtl/hazard_stall_unit_if.sv
// Pipeline-facing signals of the hazard unit: IF/ID decode fields in,
// PC / IF/ID / ID/EX steering controls out.
interface hazard_stall_unit_if;
  logic [6:0] ifid_opcode;
  logic [4:0] ifid_rs1;
  logic [4:0] ifid_rs2;
  logic [4:0] ifid_rd;
  logic       id_memread;
  logic       branch_taken;
  logic       pc_write;
  logic       ifid_write;
  logic       ifid_flush;
  logic       IDEX_control_mux;

  // Pipeline side: supplies decode fields, consumes steering controls.
  modport master (
    output ifid_opcode, ifid_rs1, ifid_rs2, ifid_rd, id_memread, branch_taken,
    input  pc_write, ifid_write, ifid_flush, IDEX_control_mux
  );

  // Hazard unit side.
  modport slave (
    input  ifid_opcode, ifid_rs1, ifid_rs2, ifid_rd, id_memread, branch_taken,
    output pc_write, ifid_write, ifid_flush, IDEX_control_mux
  );
endinterface

// File: rtl/hazard_perf_ctr.sv
// Saturating performance counter: counts inc cycles, holds at all-ones.
module hazard_perf_ctr #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next count: step on inc unless already saturated.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    cnt_d = cnt_q;
    if (inc && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
  end

  // Count register with synchronous clear.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/hazard_stall_unit.sv
// Load-use stall and taken-branch flush controller for the 5-stage core.
// Shadows the instruction entering ID/EX and compares it with IF/ID.
// Build option: define HAZARD_PERF_EN to build the stall/flush perf
// counters; otherwise stall_cnt and flush_cnt are tied to zero.
module hazard_stall_unit
  import riscv_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic                clk,
  input  logic                reset,
  hazard_stall_unit_if.slave  hz,
  output logic [CNT_W-1:0]    stall_cnt,
  output logic [CNT_W-1:0]    flush_cnt
);

  localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);

  hz_state_t  state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [4:0] ex_rd_q, ex_rd_d;
  logic       ex_memread_q, ex_memread_d;

  logic load_use;
  logic pc_write, ifid_write, ifid_flush, idex_mux;

  // Load-use hazard: a load in ID/EX writes a register IF/ID actually reads.
  always_comb begin
    load_use = (state_q == RUN) && ex_memread_q && (ex_rd_q != 5'd0) &&
               ((uses_rs1(hz.ifid_opcode) && (hz.ifid_rs1 == ex_rd_q)) ||
                (uses_rs2(hz.ifid_opcode) && (hz.ifid_rs2 == ex_rd_q)));
  end

  // FSM next state and steering outputs; a taken branch outranks load-use.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pc_write   = 1'b1;
    ifid_write = 1'b1;
    ifid_flush = 1'b0;
    idex_mux   = 1'b1;
    unique case (state_q)
      RUN: begin
        if (hz.branch_taken) begin
          ifid_flush = 1'b1;
          idex_mux   = 1'b0;
          cnt_d      = FLUSH_LOAD;
          state_d    = (FLUSH_CYCLES == 1) ? RUN : FLUSH;
        end else if (load_use) begin
          pc_write   = 1'b0;
          ifid_write = 1'b0;
          idex_mux   = 1'b0;
        end
      end
      FLUSH: begin
        // branch_taken here belongs to the squashed path and is ignored.
        ifid_flush = 1'b1;
        idex_mux   = 1'b0;
        if (cnt_q > 3'd1) begin
          cnt_d = cnt_q - 3'd1;
        end else begin
          cnt_d   = 3'd0;
          state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  // Shadow of what enters ID/EX: a bubble enters as rd=0, memread=0.
  always_comb begin
    ex_rd_d      = idex_mux ? hz.ifid_rd    : 5'd0;
    ex_memread_d = idex_mux ? hz.id_memread : 1'b0;
  end

  // State, flush counter and shadow registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= RUN;
      cnt_q        <= 3'd0;
      ex_rd_q      <= 5'd0;
      ex_memread_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      ex_rd_q      <= ex_rd_d;
      ex_memread_q <= ex_memread_d;
    end
  end

  assign hz.pc_write         = pc_write;
  assign hz.ifid_write       = ifid_write;
  assign hz.ifid_flush       = ifid_flush;
  assign hz.IDEX_control_mux = idex_mux;

`ifdef HAZARD_PERF_EN
  // Stalls count only when the branch did not pre-empt them.
  hazard_perf_ctr #(.CNT_W(CNT_W)) u_stall_ctr (
    .clk   (clk),
    .reset (reset),
    .inc   (load_use && !hz.branch_taken),
    .cnt   (stall_cnt)
  );

  hazard_perf_ctr #(.CNT_W(CNT_W)) u_flush_ctr (
    .clk   (clk),
    .reset (reset),
    .inc   ((state_q == RUN) && hz.branch_taken),
    .cnt   (flush_cnt)
  );
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Self-checking bench for hazard_stall_unit: directed vector table,
// hand-written corner sequences, then random stimulus against a model.
// Two DUTs share the stimulus: FLUSH_CYCLES=2 and FLUSH_CYCLES=1, CNT_W=4.
module tb_hazard_stall_unit;

  localparam int CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;
`ifdef HAZARD_PERF_EN
  localparam int PERF = 1;
`else
  localparam int PERF = 0;
`endif

  localparam logic [6:0] T_RTYPE = 7'b0110011;
  localparam logic [6:0] T_LOAD  = 7'b0000011;
  localparam logic [6:0] T_STORE = 7'b0100011;
  localparam logic [6:0] T_BR    = 7'b1100011;
  localparam logic [6:0] T_ADDI  = 7'b0010011;
  localparam logic [6:0] T_LUI   = 7'b0110111;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  hazard_stall_unit_if hz0 ();
  hazard_stall_unit_if hz1 ();

  assign hz1.ifid_opcode  = hz0.ifid_opcode;
  assign hz1.ifid_rs1     = hz0.ifid_rs1;
  assign hz1.ifid_rs2     = hz0.ifid_rs2;
  assign hz1.ifid_rd      = hz0.ifid_rd;
  assign hz1.id_memread   = hz0.id_memread;
  assign hz1.branch_taken = hz0.branch_taken;

  logic [CNT_W-1:0] scnt [2];
  logic [CNT_W-1:0] fcnt [2];
  logic [3:0]       outv [2];

  hazard_stall_unit #(.FLUSH_CYCLES(2), .CNT_W(CNT_W)) u_dut (
    .clk(clk), .reset(reset), .hz(hz0), .stall_cnt(scnt[0]), .flush_cnt(fcnt[0])
  );
  hazard_stall_unit #(.FLUSH_CYCLES(1), .CNT_W(CNT_W)) u_dut1 (
    .clk(clk), .reset(reset), .hz(hz1), .stall_cnt(scnt[1]), .flush_cnt(fcnt[1])
  );

  // Output vector order: {pc_write, ifid_write, ifid_flush, IDEX_control_mux}
  assign outv[0] = {hz0.pc_write, hz0.ifid_write, hz0.ifid_flush, hz0.IDEX_control_mux};
  assign outv[1] = {hz1.pc_write, hz1.ifid_write, hz1.ifid_flush, hz1.IDEX_control_mux};

  localparam logic [3:0] O_RUN   = 4'b1101;
  localparam logic [3:0] O_STALL = 4'b0000;
  localparam logic [3:0] O_FLUSH = 4'b1110;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [6:0] op, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] rd, input logic mr, input logic br);
    hz0.ifid_opcode  = op;
    hz0.ifid_rs1     = rs1;
    hz0.ifid_rs2     = rs2;
    hz0.ifid_rd      = rd;
    hz0.id_memread   = mr;
    hz0.branch_taken = br;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    drive(7'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  typedef struct {
    logic [6:0] op;
    logic [4:0] rs1, rs2, rd;
    logic       mr, br;
    logic [3:0] exp;
  } vec_t;

  vec_t vt [19];

  // Reference model (one entry per DUT)
  int         m_flen [2] = '{2, 1};
  int         m_left [2];
  logic [4:0] m_rd   [2];
  logic       m_mr   [2];
  int         m_st   [2];
  int         m_fl   [2];

  function automatic int sat(input int v);
    return (v < CMAX) ? v + 1 : v;
  endfunction

  function automatic logic reads_rs1(input logic [6:0] op);
    return op inside {T_RTYPE, T_LOAD, T_STORE, T_BR, T_ADDI};
  endfunction

  function automatic logic reads_rs2(input logic [6:0] op);
    return op inside {T_RTYPE, T_STORE, T_BR};
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_left[k] = 0; m_rd[k] = 5'd0; m_mr[k] = 1'b0; m_st[k] = 0; m_fl[k] = 0;
    end
  endtask

  initial begin
    logic [6:0] ops [6];
    logic       haz, flsh, stl, rst, bub;
    logic [3:0] e;

    ops[0] = T_RTYPE; ops[1] = T_LOAD; ops[2] = T_STORE;
    ops[3] = T_BR;    ops[4] = T_ADDI; ops[5] = T_LUI;

    //            op       rs1 rs2 rd  mr br  expected
    vt[0]  = '{T_LOAD,  5'd1, 5'd0, 5'd5, 1'b1, 1'b0, O_RUN};   // lw x5
    vt[1]  = '{T_RTYPE, 5'd5, 5'd7, 5'd6, 1'b0, 1'b0, O_STALL}; // add x6,x5,x7
    vt[2]  = '{T_RTYPE, 5'd5, 5'd7, 5'd6, 1'b0, 1'b0, O_RUN};   // released
    vt[3]  = '{T_LOAD,  5'd2, 5'd0, 5'd0, 1'b1, 1'b0, O_RUN};   // lw x0
    vt[4]  = '{T_RTYPE, 5'd0, 5'd0, 5'd6, 1'b0, 1'b0, O_RUN};   // add x6,x0,x0
    vt[5]  = '{T_LOAD,  5'd1, 5'd0, 5'd5, 1'b1, 1'b0, O_RUN};   // lw x5
    vt[6]  = '{T_ADDI,  5'd1, 5'd5, 5'd6, 1'b0, 1'b0, O_RUN};   // addi, rs2 field=5
    vt[7]  = '{T_LOAD,  5'd1, 5'd0, 5'd5, 1'b1, 1'b0, O_RUN};   // lw x5
    vt[8]  = '{T_STORE, 5'd2, 5'd5, 5'd0, 1'b0, 1'b0, O_STALL}; // sw x5 via rs2
    vt[9]  = '{T_STORE, 5'd2, 5'd5, 5'd0, 1'b0, 1'b0, O_RUN};
    vt[10] = '{T_LOAD,  5'd1, 5'd0, 5'd5, 1'b1, 1'b0, O_RUN};   // lw x5
    vt[11] = '{T_BR,    5'd5, 5'd3, 5'd0, 1'b0, 1'b1, O_FLUSH}; // branch beats load-use
    vt[12] = '{T_RTYPE, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, O_FLUSH}; // second bubble
    vt[13] = '{T_RTYPE, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, O_RUN};
    vt[14] = '{T_LOAD,  5'd1, 5'd0, 5'd5, 1'b1, 1'b0, O_RUN};   // lw x5
    vt[15] = '{T_LUI,   5'd5, 5'd5, 5'd4, 1'b0, 1'b0, O_RUN};   // opcode reads nothing
    vt[16] = '{T_RTYPE, 5'd1, 5'd2, 5'd3, 1'b0, 1'b1, O_FLUSH}; // branch
    vt[17] = '{T_RTYPE, 5'd1, 5'd2, 5'd3, 1'b0, 1'b1, O_FLUSH}; // branch in FLUSH ignored
    vt[18] = '{T_RTYPE, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, O_RUN};

    reset = 1'b1;
    drive(7'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    do_reset();

    // Reset state
    #1;
    check("reset_outputs", 32'(outv[0]), 32'(O_RUN));
    check("reset_stall_cnt", 32'(scnt[0]), 32'd0);
    check("reset_flush_cnt", 32'(fcnt[0]), 32'd0);

    // Directed vector table
    for (int i = 0; i < 19; i++) begin
      @(negedge clk);
      drive(vt[i].op, vt[i].rs1, vt[i].rs2, vt[i].rd, vt[i].mr, vt[i].br);
      #1;
      check($sformatf("vec%0d_outputs", i), 32'(outv[0]), 32'(vt[i].exp));
    end
    @(negedge clk);
    drive(7'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    #1;
    check("table_stall_cnt", 32'(scnt[0]), 32'(2 * PERF));
    check("table_flush_cnt", 32'(fcnt[0]), 32'(2 * PERF));

    // Reset asserted in the second bubble cycle of a flush
    do_reset();
    @(negedge clk);
    drive(T_RTYPE, 5'd1, 5'd2, 5'd3, 1'b0, 1'b1);
    #1;
    check("rstflush_branch_cycle", 32'(outv[0]), 32'(O_FLUSH));
    @(negedge clk);
    drive(T_RTYPE, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0);
    reset = 1'b1;
    #1;
    check("rstflush_second_bubble", 32'(outv[0]), 32'(O_FLUSH));
    check("rstflush_cnt_before", 32'(fcnt[0]), 32'(PERF));
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rstflush_after_outputs", 32'(outv[0]), 32'(O_RUN));
    check("rstflush_after_stall_cnt", 32'(scnt[0]), 32'd0);
    check("rstflush_after_flush_cnt", 32'(fcnt[0]), 32'd0);

    // Saturation: 20 load-use stalls
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      drive(T_LOAD, 5'd1, 5'd0, 5'd5, 1'b1, 1'b0);
      @(negedge clk);
      drive(T_RTYPE, 5'd5, 5'd7, 5'd6, 1'b0, 1'b0);
      #1;
      check($sformatf("sat_stall%0d", i), 32'(outv[0]), 32'(O_STALL));
    end
    @(negedge clk);
    drive(T_RTYPE, 5'd5, 5'd7, 5'd6, 1'b0, 1'b0);
    #1;
    check("sat_release", 32'(outv[0]), 32'(O_RUN));
    check("sat_stall_cnt", 32'(scnt[0]), 32'(CMAX * PERF));

    // Random stimulus against the model, both FLUSH_CYCLES variants
    do_reset();
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      begin
        logic [6:0] op;
        op  = ops[$urandom_range(0, 5)];
        rst = ($urandom_range(0, 99) == 0);
        drive(op, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
              5'($urandom_range(0, 3)),
              (op == T_LOAD) ? 1'b1 : ($urandom_range(0, 15) == 0),
              ($urandom_range(0, 7) == 0));
        reset = rst;
      end
      #1;
      for (int k = 0; k < 2; k++) begin
        haz = m_mr[k] && (m_rd[k] != 5'd0) &&
              ((reads_rs1(hz0.ifid_opcode) && hz0.ifid_rs1 == m_rd[k]) ||
               (reads_rs2(hz0.ifid_opcode) && hz0.ifid_rs2 == m_rd[k]));
        flsh = (m_left[k] > 0) || hz0.branch_taken;
        stl  = !flsh && haz;
        e    = {!stl, !stl, flsh, !(flsh || stl)};
        check($sformatf("rnd%0d_dut%0d_outputs", c, k), 32'(outv[k]), 32'(e));
        check($sformatf("rnd%0d_dut%0d_stall_cnt", c, k), 32'(scnt[k]), 32'(m_st[k] * PERF));
        check($sformatf("rnd%0d_dut%0d_flush_cnt", c, k), 32'(fcnt[k]), 32'(m_fl[k] * PERF));
        // advance model across the coming edge
        if (rst) begin
          m_left[k] = 0; m_rd[k] = 5'd0; m_mr[k] = 1'b0; m_st[k] = 0; m_fl[k] = 0;
        end else begin
          if (m_left[k] > 0) begin
            bub = 1'b1;
            m_left[k]--;
          end else if (hz0.branch_taken) begin
            bub = 1'b1;
            m_left[k] = m_flen[k] - 1;
            m_fl[k] = sat(m_fl[k]);
          end else if (haz) begin
            bub = 1'b1;
            m_st[k] = sat(m_st[k]);
          end else begin
            bub = 1'b0;
          end
          m_rd[k] = bub ? 5'd0 : hz0.ifid_rd;
          m_mr[k] = bub ? 1'b0 : hz0.id_memread;
        end
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
